// File: rtl/multicycle_control_fsm_if.sv
// Control bus between the multicycle sequencer and the RV32 subset datapath.
interface multicycle_control_fsm_if;
  logic [6:0] OP;
  logic [2:0] Funct3;
  logic [6:0] Funct7;
  logic       MemReady;
  logic       PCWrite;
  logic       IRWrite;
  logic       ULASrc;
  logic [2:0] ULAControl;
  logic       ImmSrc;
  logic       RegWrite;
  logic       MemRead;
  logic       MemWrite;
  logic       ResultSrc;
  logic       Retire;
  logic       Illegal;
  logic [3:0] State;

  // Sequencer side: reads IR fields and memory handshake, drives datapath controls.
  modport master (
    input  OP, Funct3, Funct7, MemReady,
    output PCWrite, IRWrite, ULASrc, ULAControl, ImmSrc, RegWrite,
           MemRead, MemWrite, ResultSrc, Retire, Illegal, State
  );

  // Datapath side: supplies IR fields and memory handshake, consumes controls.
  modport slave (
    output OP, Funct3, Funct7, MemReady,
    input  PCWrite, IRWrite, ULASrc, ULAControl, ImmSrc, RegWrite,
           MemRead, MemWrite, ResultSrc, Retire, Illegal, State
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Moore sequencer stepping the shared datapath through fetch/decode/execute/memory/write-back.
module multicycle_control_fsm (
  input logic                      CLK,
  input logic                      RST_N,
  multicycle_control_fsm_if.master bus
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] F7_BASE  = 7'b0000000;
  localparam logic [6:0] F7_ALT   = 7'b0100000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_EXEC_I    = 4'd3,
    S_ALU_WB    = 4'd4,
    S_MEM_ADDR  = 4'd5,
    S_MEM_READ  = 4'd6,
    S_MEM_WB    = 4'd7,
    S_MEM_WRITE = 4'd8,
    S_TRAP      = 4'd9
  } state_t;

  typedef enum logic [1:0] {CLS_R, CLS_ADDI, CLS_LB, CLS_SB} cls_t;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       ula_src;
    logic [2:0] ula_ctrl;
    logic       imm_src;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       result_src;
    logic       retire;
    logic       illegal;
  } ctrl_t;

  state_t     state_q, state_nxt, dec_state;
  cls_t       cls_q, cls_nxt, dec_cls;
  logic [2:0] alu_q, alu_nxt, dec_alu;
  logic       imm_q, imm_nxt, dec_imm;
  ctrl_t      out_q, out_nxt;

  // Instruction decode of the IR fields; only consumed while in DECODE.
  always_comb begin
    dec_state = S_TRAP;
    dec_cls   = CLS_R;
    dec_alu   = ALU_ADD;
    dec_imm   = 1'b0;
    case (bus.OP)
      OP_R: begin
        dec_state = S_EXEC_R;
        case ({bus.Funct3, bus.Funct7})
          {3'b000, F7_BASE}: dec_alu = ALU_ADD;
          {3'b000, F7_ALT}:  dec_alu = ALU_SUB;
          {3'b111, F7_BASE}: dec_alu = ALU_AND;
          {3'b110, F7_BASE}: dec_alu = ALU_OR;
          {3'b100, F7_BASE}: dec_alu = ALU_XOR;
          {3'b010, F7_BASE}: dec_alu = ALU_SLT;
          default:           dec_state = S_TRAP;
        endcase
      end
      OP_I: begin
        if (bus.Funct3 == 3'b000) begin
          dec_state = S_EXEC_I;
          dec_cls   = CLS_ADDI;
        end
      end
      OP_LOAD: begin
        if (bus.Funct3 == 3'b000) begin
          dec_state = S_MEM_ADDR;
          dec_cls   = CLS_LB;
        end
      end
      OP_STORE: begin
        if (bus.Funct3 == 3'b000) begin
          dec_state = S_MEM_ADDR;
          dec_cls   = CLS_SB;
          dec_imm   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Next state and next latched decode values.
  always_comb begin
    state_nxt = state_q;
    cls_nxt   = cls_q;
    alu_nxt   = alu_q;
    imm_nxt   = imm_q;
    case (state_q)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        state_nxt = dec_state;
        cls_nxt   = dec_cls;
        alu_nxt   = dec_alu;
        imm_nxt   = dec_imm;
      end
      S_EXEC_R, S_EXEC_I:  state_nxt = S_ALU_WB;
      S_ALU_WB, S_MEM_WB:  state_nxt = S_FETCH;
      S_MEM_ADDR:  state_nxt = (cls_q == CLS_LB) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (bus.MemReady) state_nxt = S_MEM_WB;
      S_MEM_WRITE: if (bus.MemReady) state_nxt = S_FETCH;
      S_TRAP:      state_nxt = S_TRAP;
      default:     state_nxt = S_TRAP;
    endcase
  end

  // Moore controls for the state being entered, so they can be registered.
  always_comb begin
    out_nxt = '0;
    case (state_nxt)
      S_FETCH: begin
        out_nxt.pc_write = 1'b1;
        out_nxt.ir_write = 1'b1;
      end
      S_EXEC_R, S_EXEC_I: begin
        out_nxt.ula_src  = (cls_nxt == CLS_ADDI);
        out_nxt.ula_ctrl = alu_nxt;
      end
      S_ALU_WB: begin
        out_nxt.ula_src   = (cls_nxt == CLS_ADDI);
        out_nxt.ula_ctrl  = alu_nxt;
        out_nxt.reg_write = 1'b1;
        out_nxt.retire    = 1'b1;
      end
      S_MEM_ADDR: begin
        out_nxt.ula_src = 1'b1;
        out_nxt.imm_src = imm_nxt;
      end
      S_MEM_READ: begin
        out_nxt.ula_src  = 1'b1;
        out_nxt.imm_src  = imm_nxt;
        out_nxt.mem_read = 1'b1;
      end
      S_MEM_WRITE: begin
        out_nxt.ula_src   = 1'b1;
        out_nxt.imm_src   = imm_nxt;
        out_nxt.mem_write = 1'b1;
      end
      S_MEM_WB: begin
        out_nxt.reg_write  = 1'b1;
        out_nxt.result_src = 1'b1;
        out_nxt.retire     = 1'b1;
      end
      S_TRAP:  out_nxt.illegal = 1'b1;
      default: ;
    endcase
  end

  // State, latched decode and control registers; reset lands in FETCH.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_FETCH;
      cls_q   <= CLS_R;
      alu_q   <= ALU_ADD;
      imm_q   <= 1'b0;
      out_q   <= '{pc_write: 1'b1, ir_write: 1'b1, default: '0};
    end else begin
      state_q <= state_nxt;
      cls_q   <= cls_nxt;
      alu_q   <= alu_nxt;
      imm_q   <= imm_nxt;
      out_q   <= out_nxt;
    end
  end

  // Reset forces every output low immediately; store retire waits on MemReady.
  assign bus.PCWrite    = RST_N & out_q.pc_write;
  assign bus.IRWrite    = RST_N & out_q.ir_write;
  assign bus.ULASrc     = RST_N & out_q.ula_src;
  assign bus.ULAControl = RST_N ? out_q.ula_ctrl : 3'b000;
  assign bus.ImmSrc     = RST_N & out_q.imm_src;
  assign bus.RegWrite   = RST_N & out_q.reg_write;
  assign bus.MemRead    = RST_N & out_q.mem_read;
  assign bus.MemWrite   = RST_N & out_q.mem_write;
  assign bus.ResultSrc  = RST_N & out_q.result_src;
  assign bus.Retire     = RST_N & (out_q.retire | ((state_q == S_MEM_WRITE) & bus.MemReady));
  assign bus.Illegal    = RST_N & out_q.illegal;
  assign bus.State      = RST_N ? state_q : 4'd0;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized self-checking bench: per-instruction expected output traces from an ISA-level model.
module tb_multicycle_control_fsm;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_control_fsm_if bus ();

  multicycle_control_fsm dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  localparam int K_R = 0, K_ADDI = 1, K_LB = 2, K_SB = 3, K_ILL = 4;

  // Flag bits: pcw irw usrc imm rw mr mw rs ret ill
  localparam logic [9:0] F_PC = 10'h200, F_IR = 10'h100, F_US = 10'h080, F_IM = 10'h040,
                         F_RW = 10'h020, F_MR = 10'h010, F_MW = 10'h008, F_RS = 10'h004,
                         F_RT = 10'h002, F_IL = 10'h001;

  // R-type table: ADD SUB AND OR XOR SLT, expected ULA codes 0..5
  logic [2:0] rf3 [6] = '{3'b000, 3'b000, 3'b111, 3'b110, 3'b100, 3'b010};
  logic [6:0] rf7 [6] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00};

  logic [16:0] exp_q [$];
  logic [16:0] obs_q [$];

  function automatic logic [16:0] vec(input logic [3:0] st, input logic [2:0] uc, input logic [9:0] fl);
    return {fl[9:7], uc, fl[6:0], st};
  endfunction

  function automatic logic [16:0] obs_vec();
    return {bus.PCWrite, bus.IRWrite, bus.ULASrc, bus.ULAControl, bus.ImmSrc, bus.RegWrite,
            bus.MemRead, bus.MemWrite, bus.ResultSrc, bus.Retire, bus.Illegal, bus.State};
  endfunction

  // ISA-level classification of an encoding
  task automatic classify(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                          output int kind, output logic [2:0] alu);
    kind = K_ILL;
    alu  = 3'b000;
    if (op == 7'b0110011) begin
      for (int i = 0; i < 6; i++)
        if (f3 == rf3[i] && f7 == rf7[i]) begin
          kind = K_R;
          alu  = 3'(i);
        end
    end else if (f3 == 3'b000) begin
      if (op == 7'b0010011) kind = K_ADDI;
      else if (op == 7'b0000011) kind = K_LB;
      else if (op == 7'b0100011) kind = K_SB;
    end
  endtask

  // Expected per-cycle outputs from one FETCH until the next
  task automatic build_trace(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input int w, input int ntrap);
    int kind;
    logic [2:0] alu;
    classify(op, f3, f7, kind, alu);
    exp_q.delete();
    exp_q.push_back(vec(4'd0, 3'd0, F_PC | F_IR));
    exp_q.push_back(vec(4'd1, 3'd0, 10'h0));
    case (kind)
      K_R: begin
        exp_q.push_back(vec(4'd2, alu, 10'h0));
        exp_q.push_back(vec(4'd4, alu, F_RW | F_RT));
      end
      K_ADDI: begin
        exp_q.push_back(vec(4'd3, 3'd0, F_US));
        exp_q.push_back(vec(4'd4, 3'd0, F_US | F_RW | F_RT));
      end
      K_LB: begin
        exp_q.push_back(vec(4'd5, 3'd0, F_US));
        repeat (w + 1) exp_q.push_back(vec(4'd6, 3'd0, F_US | F_MR));
        exp_q.push_back(vec(4'd7, 3'd0, F_RW | F_RS | F_RT));
      end
      K_SB: begin
        exp_q.push_back(vec(4'd5, 3'd0, F_US | F_IM));
        repeat (w) exp_q.push_back(vec(4'd8, 3'd0, F_US | F_IM | F_MW));
        exp_q.push_back(vec(4'd8, 3'd0, F_US | F_IM | F_MW | F_RT));
      end
      default: repeat (ntrap) exp_q.push_back(vec(4'd9, 3'd0, F_IL));
    endcase
  endtask

  task automatic rand_inputs();
    bus.OP       = 7'($urandom);
    bus.Funct3   = 3'($urandom);
    bus.Funct7   = 7'($urandom);
    bus.MemReady = 1'($urandom);
  endtask

  // Drive the first n cycles of the expected trace; fields only valid in DECODE
  task automatic play(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input int w, input int n);
    int mem_idx = 0;
    logic [3:0] st;
    obs_q.delete();
    for (int i = 0; i < n; i++) begin
      st = exp_q[i][3:0];
      rand_inputs();
      if (st == 4'd1) begin
        bus.OP = op; bus.Funct3 = f3; bus.Funct7 = f7;
      end
      if (st == 4'd6 || st == 4'd8) begin
        bus.MemReady = (mem_idx >= w);
        mem_idx++;
      end
      @(negedge clk);
      obs_q.push_back(obs_vec());
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rand_inputs();
    for (int c = 0; c < 3; c++) begin
      rand_inputs();
      @(negedge clk);
      n_cmp++;
      if (obs_vec() !== 17'h0) begin
        n_err++;
        $display("FAIL reset_outputs cyc%0d: got %h want %h", c, obs_vec(), 17'h0);
      end
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    build_trace(7'b0110011, 3'b000, 7'h00, 0, 0);
    play(7'b0110011, 3'b000, 7'h00, 0, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL add cyc%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 1; k < 6; k++) begin
      build_trace(7'b0110011, rf3[k], rf7[k], 0, 0);
      play(7'b0110011, rf3[k], rf7[k], 0, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (obs_q[i] !== exp_q[i]) begin
          n_err++;
          $display("FAIL rtype%0d cyc%0d: got %h want %h", k, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_addi();
    logic [6:0] f7;
    f7 = 7'($urandom);
    build_trace(7'b0010011, 3'b000, f7, 0, 0);
    play(7'b0010011, 3'b000, f7, 0, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL addi cyc%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_mem(input logic [6:0] op, input int w, input string name);
    build_trace(op, 3'b000, 7'($urandom), w, 0);
    play(op, 3'b000, 7'($urandom), w, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL %s w%0d cyc%0d: got %h want %h", name, w, i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_illegal(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input string name);
    build_trace(op, f3, f7, 0, 4);
    play(op, f3, f7, 0, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL %s cyc%0d: got %h want %h", name, i, obs_q[i], exp_q[i]);
      end
    end
    rst_n = 1'b0;
    rand_inputs();
    @(negedge clk);
    n_cmp++;
    if (obs_vec() !== 17'h0) begin
      n_err++;
      $display("FAIL %s_recover_rst: got %h want %h", name, obs_vec(), 17'h0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset_in_store_stall();
    build_trace(7'b0100011, 3'b000, 7'h00, 6, 0);
    play(7'b0100011, 3'b000, 7'h00, 6, 5);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL sb_stall cyc%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    rst_n = 1'b0;
    rand_inputs();
    bus.MemReady = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs_vec() !== 17'h0) begin
      n_err++;
      $display("FAIL sb_stall_rst: got %h want %h", obs_vec(), 17'h0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    build_trace(7'b0110011, 3'b100, 7'h00, 0, 0);
    play(7'b0110011, 3'b100, 7'h00, 0, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL post_rst_xor cyc%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [6:0] op, f7;
    logic [2:0] f3;
    int sel, w;
    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 8);
      w   = $urandom_range(0, 4);
      f7  = 7'($urandom);
      f3  = 3'b000;
      if (sel < 6) begin
        op = 7'b0110011; f3 = rf3[sel]; f7 = rf7[sel];
      end else if (sel == 6) op = 7'b0010011;
      else if (sel == 7) op = 7'b0000011;
      else op = 7'b0100011;
      build_trace(op, f3, f7, w, 0);
      play(op, f3, f7, w, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (obs_q[i] !== exp_q[i]) begin
          n_err++;
          $display("FAIL random%0d op%b cyc%0d: got %h want %h", t, op, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_addi();
    test_mem(7'b0000011, 3, "lb");
    test_mem(7'b0100011, 0, "sb");
    test_mem(7'b0100011, 2, "sb");
    test_mem(7'b0000011, 0, "lb");
    test_illegal(7'b0110011, 3'b000, 7'b0000001, "ill_f7");
    test_illegal(7'b1101111, 3'($urandom), 7'($urandom), "ill_jal");
    test_reset_in_store_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
